frame_store: RTL and testbench

Single-clock store-and-forward frame queue between a MAC receive port and the opposite port's transmit controller. It accepts bytes from the MAC receive interface and commits each frame only after its receive status vector arrives. It then presents committed frames, with their byte lengths, to the transmit controller under a valid/ready handshake. It replaces the byte FIFO plus edge-triggered length capture with one synchronous, frame-atomic buffer, and raises a high-water flag for the pause-frame controller.

---
 rtl/frame_store_pkg.sv | 25 ++
 rtl/frame_store_if.sv | 29 ++
 rtl/frame_len_fifo.sv | 55 +++++
 rtl/frame_store.sv | 200 ++++++++++++++++++++
 tb/tb_frame_store.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/frame_store_pkg.sv
// frame_store_pkg: shared state encodings, widths and helpers for the frame store.
package frame_store_pkg;

  localparam int unsigned STAT_GOOD_BIT = 0;
  localparam int unsigned LEN_W         = 16;
  localparam int unsigned STAT_W        = 27;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_DROP,
    W_STAT
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_LOAD,
    R_DATA
  } rd_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/frame_store_if.sv
// frame_store_if: MAC receive, transmit handshake and status signals of the frame store.
interface frame_store_if;
  import frame_store_pkg::*;

  logic [7:0]        rx_mac_data;
  logic              rx_mac_valid;
  logic              rx_mac_last;
  logic [STAT_W-1:0] rx_stat_vector;
  logic              rx_stat_valid;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_last;
  logic              tx_ready;
  logic [LEN_W-1:0]  frm_len;
  logic              frm_avail;
  logic              fifo_full;
  logic [15:0]       drop_cnt;

  modport slave (
    input  rx_mac_data, rx_mac_valid, rx_mac_last, rx_stat_vector, rx_stat_valid, tx_ready,
    output tx_data, tx_valid, tx_last, frm_len, frm_avail, fifo_full, drop_cnt
  );

  modport master (
    output rx_mac_data, rx_mac_valid, rx_mac_last, rx_stat_vector, rx_stat_valid, tx_ready,
    input  tx_data, tx_valid, tx_last, frm_len, frm_avail, fifo_full, drop_cnt
  );

endinterface

// File: rtl/frame_len_fifo.sv
// frame_len_fifo: synchronous first-word-fall-through queue of committed frame lengths.
module frame_len_fifo
  import frame_store_pkg::*;
#(
  parameter int unsigned AW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [LEN_W-1:0] push_data,
  input  logic             pop,
  output logic [LEN_W-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [LEN_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A push into a full queue is still honoured when the head leaves in the same cycle.
  always_comb begin
    empty   = (count == '0);
    full    = count[AW];
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    head    = mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_idx <= wr_idx + AW'(1);
      if (do_pop)  rd_idx <= rd_idx + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frame_store.sv
// frame_store: frame-atomic store-and-forward byte queue with per-frame length queue.
// Define FRAME_STORE_DROP_BAD_EN to also drop frames whose receive status marks them bad.
module frame_store
  import frame_store_pkg::*;
#(
  parameter int unsigned DATA_AW    = 11,
  parameter int unsigned LEN_AW     = 4,
  parameter int unsigned HIGH_WATER = 1536
) (
  input  logic         clk,
  input  logic         rst_n,
  frame_store_if.slave bus
);

  localparam int unsigned      PTR_W   = DATA_AW + 1;
  localparam int unsigned      DEPTH   = 1 << DATA_AW;
  localparam logic [PTR_W-1:0] DEPTH_P = {1'b1, {DATA_AW{1'b0}}};
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_TWO = LEN_W'(2);

  logic [7:0]         mem [DEPTH];
  logic [7:0]         ram_q;
  logic               ram_we;
  logic               ram_re;
  logic [DATA_AW-1:0] ram_ra;

  wr_state_t          wr_state;
  rd_state_t          rd_state;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   wr_commit;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   rd_next;
  logic [PTR_W-1:0]   used;
  logic [PTR_W-1:0]   space;
  logic [LEN_W-1:0]   wcount;
  logic [LEN_W-1:0]   rem;
  logic               ovf;
  logic [15:0]        drop_cnt;
  logic               tx_valid;
  logic               tx_last;
  logic               fifo_full;

  logic               lq_push;
  logic               lq_pop;
  logic               lq_empty;
  logic               lq_full;
  logic [LEN_W-1:0]   lq_head;
  logic               stat_ok;
  logic               beat;
  logic               frm_avail;
  logic               stat_unused;

  always_comb begin
    used      = wr_commit - rd_ptr;
    space     = DEPTH_P - (wr_ptr - rd_ptr);
    rd_next   = rd_ptr + PTR_ONE;
    frm_avail = !lq_empty;
    beat      = tx_valid && bus.tx_ready;
    ram_we    = ((wr_state == W_IDLE) || (wr_state == W_DATA)) && bus.rx_mac_valid
                && (space != '0);
`ifdef FRAME_STORE_DROP_BAD_EN
    stat_ok   = bus.rx_stat_vector[STAT_GOOD_BIT] && !ovf && !lq_full;
`else
    stat_ok   = !ovf && !lq_full;
`endif
    lq_push   = (wr_state == W_STAT) && bus.rx_stat_valid && stat_ok;
    lq_pop    = (rd_state == R_DATA) && beat && tx_last;
    // Prefetch the following byte on each non-final beat so beats can run back to back.
    ram_re    = ((rd_state == R_IDLE) && frm_avail)
                || ((rd_state == R_DATA) && beat && !tx_last);
    ram_ra    = (rd_state == R_IDLE) ? rd_ptr[DATA_AW-1:0] : rd_next[DATA_AW-1:0];
  end

  // The receive byte count in the status vector is not used; the stored length is wcount.
  assign stat_unused = ^bus.rx_stat_vector;

  always_ff @(posedge clk) begin
    if (ram_we) mem[wr_ptr[DATA_AW-1:0]] <= bus.rx_mac_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_q <= '0;
    end else if (ram_re) begin
      ram_q <= mem[ram_ra];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state  <= W_IDLE;
      wr_ptr    <= '0;
      wr_commit <= '0;
      wcount    <= '0;
      ovf       <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      case (wr_state)
        W_IDLE, W_DATA: begin
          if (bus.rx_mac_valid) begin
            if (space == '0) begin
              ovf      <= 1'b1;
              wr_state <= bus.rx_mac_last ? W_STAT : W_DROP;
            end else begin
              wr_ptr   <= wr_ptr + PTR_ONE;
              wcount   <= wcount + LEN_ONE;
              wr_state <= bus.rx_mac_last ? W_STAT : W_DATA;
            end
          end
        end
        W_DROP: begin
          if (bus.rx_mac_valid && bus.rx_mac_last) wr_state <= W_STAT;
        end
        W_STAT: begin
          if (bus.rx_stat_valid) begin
            if (stat_ok) begin
              wr_commit <= wr_ptr;
            end else begin
              wr_ptr   <= wr_commit;
              drop_cnt <= sat_inc16(drop_cnt);
            end
            wcount   <= '0;
            ovf      <= 1'b0;
            wr_state <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= R_IDLE;
      rd_ptr   <= '0;
      rem      <= '0;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (frm_avail) begin
            rem      <= lq_head;
            rd_state <= R_LOAD;
          end
        end
        R_LOAD: begin
          tx_valid <= 1'b1;
          tx_last  <= (rem == LEN_ONE);
          rd_state <= R_DATA;
        end
        R_DATA: begin
          if (beat) begin
            rd_ptr <= rd_next;
            if (tx_last) begin
              tx_valid <= 1'b0;
              tx_last  <= 1'b0;
              rd_state <= R_IDLE;
            end else begin
              rem     <= rem - LEN_ONE;
              tx_last <= (rem == LEN_TWO);
            end
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_full <= 1'b0;
    end else begin
      fifo_full <= (32'(used) >= HIGH_WATER);
    end
  end

  frame_len_fifo #(
    .AW (LEN_AW)
  ) u_len_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (lq_push),
    .push_data (wcount),
    .pop       (lq_pop),
    .head      (lq_head),
    .empty     (lq_empty),
    .full      (lq_full)
  );

  assign bus.tx_data   = ram_q;
  assign bus.tx_valid  = tx_valid;
  assign bus.tx_last   = tx_last;
  assign bus.frm_len   = lq_empty ? '0 : lq_head;
  assign bus.frm_avail = frm_avail;
  assign bus.fifo_full = fifo_full;
  assign bus.drop_cnt  = drop_cnt;

endmodule

// File: tb/tb_frame_store.sv
// tb_frame_store: directed stimulus with a beat scoreboard for frame_store.
module tb_frame_store;
  import frame_store_pkg::*;

  typedef struct packed {
    logic [7:0]  data;
    logic        last;
    logic [15:0] len;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  frame_store_if bus ();

  frame_store #(
    .DATA_AW    (11),
    .LEN_AW     (4),
    .HIGH_WATER (1536)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int    checks    = 0;
  int    errors    = 0;
  int    exp_drop  = 0;
  bit    rnd_ready = 1'b0;
  beat_t sb[$];
  int    lens[10]  = '{1, 2, 63, 64, 65, 128, 150, 200, 17, 255};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) bus.tx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_frame(input int len, input int base, input bit good, input bit commit);
    beat_t b;
    if (commit) begin
      for (int i = 0; i < len; i++) begin
        b.data = 8'(base + i);
        b.last = (i == len - 1);
        b.len  = 16'(len);
        sb.push_back(b);
      end
    end else begin
      exp_drop++;
    end
    for (int i = 0; i < len; i++) begin
      bus.rx_mac_valid = 1'b1;
      bus.rx_mac_data  = 8'(base + i);
      bus.rx_mac_last  = (i == len - 1);
      tick();
    end
    bus.rx_mac_valid = 1'b0;
    bus.rx_mac_last  = 1'b0;
    tick();
    bus.rx_stat_valid  = 1'b1;
    bus.rx_stat_vector = {5'd0, 16'(len), 5'd0, good};
    tick();
    bus.rx_stat_valid  = 1'b0;
    bus.rx_stat_vector = '0;
  endtask

  task automatic drain(input string tag, input int budget);
    int c = 0;
    while ((sb.size() != 0 || bus.tx_valid) && c < budget) begin
      tick();
      c++;
    end
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    chk({tag, "_avail"}, 32'(bus.frm_avail), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_tx_data"},   32'(bus.tx_data),   32'd0);
    chk({tag, "_tx_valid"},  32'(bus.tx_valid),  32'd0);
    chk({tag, "_tx_last"},   32'(bus.tx_last),   32'd0);
    chk({tag, "_frm_len"},   32'(bus.frm_len),   32'd0);
    chk({tag, "_frm_avail"}, 32'(bus.frm_avail), 32'd0);
    chk({tag, "_fifo_full"}, 32'(bus.fifo_full), 32'd0);
    chk({tag, "_drop_cnt"},  32'(bus.drop_cnt),  32'd0);
  endtask

  // Every presented beat, stalled or not, must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.tx_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", 32'(bus.tx_valid), 32'd0);
      end else begin
        chk("tx_data", 32'(bus.tx_data), 32'(sb[0].data));
        chk("tx_last", 32'(bus.tx_last), 32'(sb[0].last));
        chk("frm_len", 32'(bus.frm_len), 32'(sb[0].len));
        if (bus.tx_ready) sb.delete(0);
      end
    end
  end

  initial begin
    bus.rx_mac_data    = '0;
    bus.rx_mac_valid   = 1'b0;
    bus.rx_mac_last    = 1'b0;
    bus.rx_stat_vector = '0;
    bus.rx_stat_valid  = 1'b0;
    bus.tx_ready       = 1'b0;
    #3;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.tx_ready = 1'b1;

    // Single 64-byte frame: availability and first-beat latency after commit.
    send_frame(64, 0, 1'b1, 1'b1);
    chk("t1_avail_n1", 32'(bus.frm_avail), 32'd1);
    chk("t1_valid_n1", 32'(bus.tx_valid), 32'd0);
    tick();
    chk("t1_valid_n2", 32'(bus.tx_valid), 32'd0);
    tick();
    chk("t1_valid_n3", 32'(bus.tx_valid), 32'd1);
    drain("t1", 400);
    chk("t1_drop", 32'(bus.drop_cnt), 32'(exp_drop));

    // Status strobe while idle must be ignored.
    bus.rx_stat_valid  = 1'b1;
    bus.rx_stat_vector = {5'd0, 16'd64, 5'd0, 1'b1};
    tick();
    bus.rx_stat_valid  = 1'b0;
    bus.rx_stat_vector = '0;
    tick();
    chk("stray_avail", 32'(bus.frm_avail), 32'd0);
    chk("stray_drop", 32'(bus.drop_cnt), 32'(exp_drop));

    // Bad-status frame followed by a good one.
`ifdef FRAME_STORE_DROP_BAD_EN
    send_frame(100, 8'h80, 1'b0, 1'b0);
`else
    send_frame(100, 8'h80, 1'b0, 1'b1);
`endif
    send_frame(60, 8'hC0, 1'b1, 1'b1);
    drain("t2", 600);
    chk("t2_drop", 32'(bus.drop_cnt), 32'(exp_drop));

    // Oversized frame overflows the RAM and is dropped; the next frame is intact.
    send_frame(2100, 8'h05, 1'b1, 1'b0);
    chk("t3_avail", 32'(bus.frm_avail), 32'd0);
    chk("t3_drop", 32'(bus.drop_cnt), 32'(exp_drop));
    send_frame(64, 8'h33, 1'b1, 1'b1);
    drain("t3", 400);

    // Seventeen frames while stalled: the length queue holds sixteen.
    bus.tx_ready = 1'b0;
    for (int k = 0; k < 17; k++) send_frame(64, k * 8, 1'b1, k < 16);
    chk("t4_drop", 32'(bus.drop_cnt), 32'(exp_drop));
    chk("t4_avail", 32'(bus.frm_avail), 32'd1);
    chk("t4_full", 32'(bus.fifo_full), 32'd0);
    bus.tx_ready = 1'b1;
    drain("t4", 2000);

    // High-water flag at exactly 1536 committed bytes, one cycle after the commit.
    bus.tx_ready = 1'b0;
    for (int k = 0; k < 6; k++) send_frame(220, k * 16 + 3, 1'b1, 1'b1);
    tick();
    chk("t5_full_1320", 32'(bus.fifo_full), 32'd0);
    send_frame(216, 8'h77, 1'b1, 1'b1);
    chk("t5_full_n1", 32'(bus.fifo_full), 32'd0);
    tick();
    chk("t5_full_n2", 32'(bus.fifo_full), 32'd1);
    bus.tx_ready = 1'b1;
    drain("t5", 3000);
    chk("t5_full_after", 32'(bus.fifo_full), 32'd0);

    // Random backpressure across ten frames of varied length.
    rnd_ready = 1'b1;
    for (int k = 0; k < 10; k++) send_frame(lens[k], 8'h40 + k * 16, 1'b1, 1'b1);
    drain("t6", 6000);
    rnd_ready    = 1'b0;
    bus.tx_ready = 1'b1;
    chk("t6_drop", 32'(bus.drop_cnt), 32'(exp_drop));

    // Reset while one frame is being read and another is being written.
    send_frame(200, 8'h11, 1'b1, 1'b1);
    for (int i = 0; i < 50; i++) begin
      bus.rx_mac_valid = 1'b1;
      bus.rx_mac_data  = 8'(i);
      bus.rx_mac_last  = 1'b0;
      tick();
    end
    chk("t7_mid_read", 32'(bus.tx_valid), 32'd1);
    rst_n            = 1'b0;
    bus.rx_mac_valid = 1'b0;
    sb.delete();
    exp_drop = 0;
    #1;
    check_zero("t7_reset");
    tick();
    tick();
    rst_n = 1'b1;
    send_frame(64, 8'hE0, 1'b1, 1'b1);
    drain("t7", 400);
    chk("t7_drop", 32'(bus.drop_cnt), 32'(exp_drop));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
